// File: rtl/gcd_pkg.sv
// Shared types and defaults for the GCD control FSM.
// The GCD_CTRL_TIMEOUT_EN build option adds the iteration-limit abort.
package gcd_pkg;

  localparam int unsigned MAX_ITER_DEF = 255;
  localparam int unsigned CNT_W_DEF    = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    CALC = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_e;

  typedef struct packed {
    logic gt;
    logic lt;
    logic eq;
  } flags_t;

endpackage

// File: rtl/gcd_controller_if.sv
// Handshake, datapath status and datapath control bundle
// between the GCD controller and its surroundings.
interface gcd_controller_if;

  logic start;
  logic a_gt_b;
  logic a_lt_b;
  logic a_eq_b;
  logic a_ld;
  logic b_ld;
  logic a_sel;
  logic b_sel;
  logic output_en;
  logic busy;
  logic done;
  logic err;

  modport master (
    input  start,
    input  a_gt_b,
    input  a_lt_b,
    input  a_eq_b,
    output a_ld,
    output b_ld,
    output a_sel,
    output b_sel,
    output output_en,
    output busy,
    output done,
    output err
  );

  modport slave (
    output start,
    output a_gt_b,
    output a_lt_b,
    output a_eq_b,
    input  a_ld,
    input  b_ld,
    input  a_sel,
    input  b_sel,
    input  output_en,
    input  busy,
    input  done,
    input  err
  );

endinterface

// File: rtl/gcd_iter_counter.sv
// Saturating subtraction-step counter; clear wins over increment.
// Used by gcd_controller only when GCD_CTRL_TIMEOUT_EN is defined.
module gcd_iter_counter
  import gcd_pkg::*;
#(
  parameter int unsigned CNT_W    = CNT_W_DEF,
  parameter int unsigned MAX_ITER = MAX_ITER_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic at_limit_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign at_limit_o = (cnt_q == CNT_W'(MAX_ITER));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !at_limit_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/gcd_controller.sv
// Control FSM for the subtract-and-compare GCD datapath.
// Define GCD_CTRL_TIMEOUT_EN to abort after MAX_ITER subtractions.
module gcd_controller
  import gcd_pkg::*;
#(
  parameter int unsigned MAX_ITER = MAX_ITER_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input logic              clk,
  input logic              rst,
  gcd_controller_if.master bus
);

  state_e state_q, state_d;
  flags_t fl;
  logic   legal;
  logic   at_limit;

  if ((MAX_ITER >> CNT_W) != 0) begin : g_bad_cfg
    $error("CNT_W too narrow for MAX_ITER");
  end

  assign fl    = {bus.a_gt_b, bus.a_lt_b, bus.a_eq_b};
  assign legal = $onehot(fl);

`ifdef GCD_CTRL_TIMEOUT_EN
  logic cnt_clr;
  logic cnt_inc;

  assign cnt_clr = (state_q == IDLE) && bus.start;
  assign cnt_inc = (state_q == CALC) && legal
                && !fl.eq && !at_limit;

  gcd_iter_counter #(
    .CNT_W    (CNT_W),
    .MAX_ITER (MAX_ITER)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (cnt_clr),
    .inc_i      (cnt_inc),
    .at_limit_o (at_limit)
  );
`else
  assign at_limit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    bus.a_ld      = 1'b0;
    bus.b_ld      = 1'b0;
    bus.a_sel     = 1'b0;
    bus.b_sel     = 1'b0;
    bus.output_en = 1'b0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    bus.err       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) state_d = LOAD;
      end
      LOAD: begin
        bus.a_ld = 1'b1;
        bus.b_ld = 1'b1;
        bus.busy = 1'b1;
        state_d  = CALC;
      end
      CALC: begin
        bus.busy = 1'b1;
        // a faulting cycle must not disturb A, B or the result
        if (!legal || (!fl.eq && at_limit)) begin
          state_d = ERR;
        end else begin
          unique case (1'b1)
            fl.eq: begin
              bus.output_en = 1'b1;
              state_d       = DONE;
            end
            fl.gt: begin
              bus.a_ld  = 1'b1;
              bus.a_sel = 1'b1;
            end
            fl.lt: begin
              bus.b_ld  = 1'b1;
              bus.b_sel = 1'b1;
            end
            default: ;
          endcase
        end
      end
      DONE: begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end
      ERR: begin
        bus.done = 1'b1;
        bus.err  = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_gcd_controller.sv
// Scoreboard bench for gcd_controller with a behavioural GCD datapath.
// Expectations adapt to GCD_CTRL_TIMEOUT_EN.
module tb_gcd_controller;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  gcd_controller_if bus();

  gcd_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] in1 = 8'd0;
  logic [7:0] in2 = 8'd0;
  logic [7:0] a_q = 8'd0;
  logic [7:0] b_q = 8'd0;
  logic [7:0] out_q = 8'd0;
  logic       ovr = 1'b0;
  logic [2:0] ovr_f = 3'b000;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int oe_cnt = 0;

  typedef struct {
    int         k0;
    int         lat;
    logic       err;
    logic [7:0] out;
  } exp_t;

  exp_t sb[$];

  assign bus.a_gt_b = ovr ? ovr_f[2] : (a_q > b_q);
  assign bus.a_lt_b = ovr ? ovr_f[1] : (a_q < b_q);
  assign bus.a_eq_b = ovr ? ovr_f[0] : (a_q == b_q);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.a_ld) a_q <= bus.a_sel ? a_q - b_q : in1;
    if (bus.b_ld) b_q <= bus.b_sel ? b_q - a_q : in2;
    if (bus.output_en) out_q <= b_q;
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  function automatic logic [7:0] outs();
    return {bus.a_ld, bus.b_ld, bus.a_sel, bus.b_sel,
            bus.output_en, bus.busy, bus.done, bus.err};
  endfunction

  // monitor: pops one expectation per done pulse
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bus.output_en) oe_cnt++;
      if (bus.done) begin
        chk("done_expected", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("err", 32'(bus.err), 32'(e.err));
          chk("latency", cyc - e.k0 + 1, e.lat);
          chk("out", 32'(out_q), 32'(e.out));
        end
      end
    end
  end

  task automatic issue(input logic [7:0] x,
                       input logic [7:0] y,
                       input bit push,
                       input logic e,
                       input int lat,
                       input logic [7:0] o);
    exp_t it;
    @(negedge clk);
    in1 = x;
    in2 = y;
    bus.start = 1'b1;
    if (push) begin
      it.k0  = cyc + 1;
      it.lat = lat;
      it.err = e;
      it.out = o;
      sb.push_back(it);
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    int n;
    n = 0;
    while (sb.size() != 0 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb.size(), 0);
    sb.delete();
  endtask

  task automatic bad(input logic [2:0] f);
    issue(8'd20, 8'd6, 1'b1, 1'b1, 3, 8'd7);
    @(negedge clk);
    ovr   = 1'b1;
    ovr_f = f;
    #1;
    chk("bad_strobes",
        {bus.a_ld, bus.b_ld, bus.output_en}, 0);
    @(negedge clk);
    ovr = 1'b0;
    wait_done(10);
  endtask

  initial begin
    int n;
    int snap;
    bus.start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs", outs(), 0);
    @(negedge clk);
    bus.start = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_outs", outs(), 0);

    issue(8'd12, 8'd8, 1'b1, 1'b0, 5, 8'd4);
    wait_done(50);

    issue(8'd255, 8'd1, 1'b1, 1'b0, 257, 8'd1);
    wait_done(400);

    // start pulses in CALC and in DONE must not restart
    issue(8'd12, 8'd8, 1'b1, 1'b0, 5, 8'd4);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (!bus.done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("saw_done", 32'(bus.done), 1);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    chk("no_restart", 32'(bus.busy), 0);
    wait_done(10);

    issue(8'd7, 8'd7, 1'b1, 1'b0, 3, 8'd7);
    wait_done(20);

    bad(3'b110);
    bad(3'b000);
    bad(3'b011);

`ifdef GCD_CTRL_TIMEOUT_EN
    snap = oe_cnt;
    issue(8'd0, 8'd5, 1'b1, 1'b1, 258, 8'd7);
    wait_done(400);
    chk("no_output_en", oe_cnt - snap, 0);
    issue(8'd255, 8'd1, 1'b0, 1'b0, 0, 8'd0);
    repeat (20) @(negedge clk);
`else
    snap = oe_cnt;
    issue(8'd0, 8'd5, 1'b0, 1'b0, 0, 8'd0);
    repeat (1000) @(negedge clk);
    chk("stuck_busy", 32'(bus.busy), 1);
    chk("no_output_en", oe_cnt - snap, 0);
`endif

    // asynchronous abort mid-CALC
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_async", outs(), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_idle", 32'(bus.busy), 0);

    issue(8'd7, 8'd7, 1'b1, 1'b0, 3, 8'd7);
    wait_done(20);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
